// File: rtl/stream_packer_pkg.sv
// Shared types and helpers for the stream_packer width-up converter.
// Assembly-side state encoding plus beat-slot offset arithmetic.
package stream_packer_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Bit offset of beat slot 'slot' inside a packed word of 'width'-bit beats.
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/register_slice.sv
// Generic enable-gated register with synchronous active-high reset.
// Holds the packer's output word and its assembly state.
module register_slice #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/stream_packer.sv
// Valid/ready width-up converter: packs NUM_BEATS beats into one word, first beat in the LSBs.
// Optional end-of-packet support via `define STREAM_PACKER_LAST_EN (adds last_in / last_out).
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BEATS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            valid_in,
    output logic                            ready_in,
`ifdef STREAM_PACKER_LAST_EN
    input  logic                            last_in,
    output logic                            last_out,
`endif
    output logic [NUM_BEATS*DATA_WIDTH-1:0] data_out,
    output logic                            valid_out,
    input  logic                            ready_out
);

    localparam int CNT_WIDTH = $clog2(NUM_BEATS) + 1;
    localparam int WORD_W    = NUM_BEATS * DATA_WIDTH;

    state_t                state_q, state_d;
    logic [1:0]            state_bits;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0]     asm_q, asm_d, merged;
    logic                  ready_q;
    logic                  insert, remove, out_free, is_final, last_w;
    logic                  out_en;
    logic [WORD_W:0]       out_d, out_q;

`ifdef STREAM_PACKER_LAST_EN
    logic asm_last_q, asm_last_d, last_d;
    assign last_w = last_in;
`else
    assign last_w = 1'b0;
`endif

    assign ready_in  = ready_q;
    assign valid_out = out_q[WORD_W];
    assign data_out  = out_q[WORD_W-1:0];
    assign state_q   = state_t'(state_bits);

    // Word as it would look with the current beat dropped into slot cnt_q; slots above stay zero.
    always_comb begin
        merged = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            if (k < int'(cnt_q))
                merged[slot_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = asm_q[slot_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
            else if (k == int'(cnt_q))
                merged[slot_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = data_in;
        end
    end

    always_comb begin
        insert   = valid_in & ready_q;
        remove   = valid_out & ready_out;
        out_free = !valid_out | ready_out;
        is_final = (cnt_q == CNT_WIDTH'(NUM_BEATS - 1)) | last_w;

        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        out_en  = 1'b0;
        out_d   = {valid_out, data_out};
`ifdef STREAM_PACKER_LAST_EN
        asm_last_d = asm_last_q;
        last_d     = last_out;
`endif

        if (state_q == FULL) begin
            if (remove) begin
                out_en  = 1'b1;
                out_d   = {1'b1, asm_q};
                asm_d   = '0;
                cnt_d   = '0;
                state_d = EMPTY;
`ifdef STREAM_PACKER_LAST_EN
                last_d     = asm_last_q;
                asm_last_d = 1'b0;
`endif
            end
        end else if (insert && is_final) begin
            if (out_free) begin
                out_en  = 1'b1;
                out_d   = {1'b1, merged};
                asm_d   = '0;
                cnt_d   = '0;
                state_d = EMPTY;
`ifdef STREAM_PACKER_LAST_EN
                last_d = last_w;
`endif
            end else begin
                // Output still occupied: park the finished word until it drains.
                asm_d   = merged;
                state_d = FULL;
`ifdef STREAM_PACKER_LAST_EN
                asm_last_d = last_w;
`endif
            end
        end else if (insert) begin
            asm_d   = merged;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = PARTIAL;
        end

        // Drained with nothing to replace it: drop valid but keep the data bits.
        if (remove && !out_en) begin
            out_en        = 1'b1;
            out_d[WORD_W] = 1'b0;
`ifdef STREAM_PACKER_LAST_EN
            last_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ready_q <= (state_d != FULL);
        end
    end

    register_slice #(.WIDTH(2), .RESET_VAL(EMPTY)) u_state (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_d),
        .q   (state_bits)
    );

    register_slice #(.WIDTH(WORD_W + 1), .RESET_VAL('0)) u_out (
        .clk (clk),
        .rst (rst),
        .en  (out_en),
        .d   (out_d),
        .q   (out_q)
    );

`ifdef STREAM_PACKER_LAST_EN
    always_ff @(posedge clk) begin
        if (rst)
            asm_last_q <= 1'b0;
        else
            asm_last_q <= asm_last_d;
    end

    register_slice #(.WIDTH(1), .RESET_VAL(1'b0)) u_last (
        .clk (clk),
        .rst (rst),
        .en  (out_en),
        .d   (last_d),
        .q   (last_out)
    );
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer: a 4-beat and a 1-beat instance share one input stream and are
// each checked every cycle against a queue-of-words model; honours STREAM_PACKER_LAST_EN.
module tb_stream_packer;

`ifdef STREAM_PACKER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        valid_in, ready_out, last_in;
    logic        ready_in4, valid_out4, ready_in1, valid_out1;
    logic [31:0] data_out4;
    logic [7:0]  data_out1;
`ifdef STREAM_PACKER_LAST_EN
    logic        last_out4, last_out1;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Model: beats accumulated per instance, finished words (bit 32 = last) awaiting removal.
    int          n_of [2] = '{4, 1};
    logic [31:0] acc  [2];
    int          k    [2];
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    stream_packer #(.DATA_WIDTH(8), .NUM_BEATS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in4),
`ifdef STREAM_PACKER_LAST_EN
        .last_in   (last_in),
        .last_out  (last_out4),
`endif
        .data_out  (data_out4),
        .valid_out (valid_out4),
        .ready_out (ready_out)
    );

    stream_packer #(.DATA_WIDTH(8), .NUM_BEATS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in1),
`ifdef STREAM_PACKER_LAST_EN
        .last_in   (last_in),
        .last_out  (last_out1),
`endif
        .data_out  (data_out1),
        .valid_out (valid_out1),
        .ready_out (ready_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input bit ins, input bit rem);
        logic [32:0] w;
        if (rem) begin
            if (d == 0 && q0.size() > 0) void'(q0.pop_front());
            if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        end
        if (ins) begin
            acc[d] = acc[d] | (32'(data_in) << (8 * k[d]));
            k[d]++;
            if (k[d] == n_of[d] || (LAST_EN && last_in)) begin
                w = {LAST_EN & last_in, acc[d]};
                if (d == 0) q0.push_back(w);
                else        q1.push_back(w);
                acc[d] = '0;
                k[d]   = 0;
            end
        end
    endtask

    task automatic tick();
        bit pr4, pv4, pr1, pv1;
        pr4 = ready_in4; pv4 = valid_out4;
        pr1 = ready_in1; pv1 = valid_out1;
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete();
            acc[0] = '0; acc[1] = '0; k[0] = 0; k[1] = 0;
        end else begin
            model_step(0, valid_in & pr4, pv4 & ready_out);
            model_step(1, valid_in & pr1, pv1 & ready_out);
        end
        #1;
        check("rdy4", ready_in4, q0.size() < 2);
        check("vld4", valid_out4, q0.size() > 0);
        if (q0.size() > 0) check("dat4", data_out4, q0[0][31:0]);
        check("rdy1", ready_in1, q1.size() < 2);
        check("vld1", valid_out1, q1.size() > 0);
        if (q1.size() > 0) check("dat1", {24'b0, data_out1}, q1[0][31:0]);
`ifdef STREAM_PACKER_LAST_EN
        if (q0.size() > 0) check("lst4", last_out4, q0[0][32]);
        if (q1.size() > 0) check("lst1", last_out1, q1[0][32]);
`endif
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic ro, input logic l);
        data_in   = d;
        valid_in  = v;
        ready_out = ro;
        last_in   = l;
        tick();
    endtask

    initial begin
        rst = 1'b1; data_in = '0; valid_in = 1'b0; ready_out = 1'b0; last_in = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_rdy", ready_in4, 1'b1);
        check("rst_vld", valid_out4, 1'b0);
        check("rst_dat", data_out4, 32'h0);
        rst = 1'b0;

        // One word back-to-back, visible the cycle after the 4th beat.
        drive(8'h11, 1'b1, 1'b1, 1'b0);
        drive(8'h22, 1'b1, 1'b1, 1'b0);
        drive(8'h33, 1'b1, 1'b1, 1'b0);
        drive(8'h44, 1'b1, 1'b1, 1'b0);
        check("w1_dat", data_out4, 32'h44332211);
        check("w1_vld", valid_out4, 1'b1);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("w1_clr", valid_out4, 1'b0);

        // Eight continuous beats, no bubble.
        for (int i = 1; i <= 8; i++) begin
            drive(8'(i), 1'b1, 1'b1, 1'b0);
            check("str_rdy", ready_in4, 1'b1);
            if (i == 4) check("str_w0", data_out4, 32'h04030201);
            if (i == 8) check("str_w1", data_out4, 32'h08070605);
        end
        drive(8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure: second word parks in FULL until the first drains.
        for (int i = 1; i <= 8; i++) begin
            drive(8'(i), 1'b1, 1'b0, 1'b0);
            if (i >= 4) check("bp_hold", data_out4, 32'h04030201);
        end
        check("bp_full", ready_in4, 1'b0);
        drive(8'h99, 1'b1, 1'b0, 1'b0);
        check("bp_ign", data_out4, 32'h04030201);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("bp_w1", data_out4, 32'h08070605);
        check("bp_rdy", ready_in4, 1'b1);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("bp_clr", valid_out4, 1'b0);

        // Reset mid-word discards the partial beats.
        drive(8'hAA, 1'b1, 1'b1, 1'b0);
        drive(8'hBB, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) drive(8'(i), 1'b1, 1'b1, 1'b0);
        check("rst_w", data_out4, 32'h04030201);
        drive(8'h00, 1'b0, 1'b1, 1'b0);

`ifdef STREAM_PACKER_LAST_EN
        drive(8'h11, 1'b1, 1'b1, 1'b0);
        drive(8'h22, 1'b1, 1'b1, 1'b1);
        check("lst_dat", data_out4, 32'h00002211);
        check("lst_flg", last_out4, 1'b1);
        for (int i = 1; i <= 4; i++) drive(8'(i), 1'b1, 1'b1, 1'b0);
        check("lst_nxt", data_out4, 32'h04030201);
        check("lst_nfl", last_out4, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic with toggling backpressure.
        for (int i = 0; i < 400; i++)
            drive(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  LAST_EN && ($urandom_range(0, 7) == 0));

        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("drain4", valid_out4, 1'b0);
        check("drain1", valid_out1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Valid/ready width-up converter. Collects NUM_BEATS consecutive DATA_WIDTH beats into one NUM_BEATS*DATA_WIDTH word.
- Sits directly downstream of a skid_buffer stage and consumes its output stream, for example serial quantised elements packed into a vector for the low-rank matmul datapath.
- Fully registered outputs. Sustains one beat per cycle when the downstream is ready.

Parameters:
- DATA_WIDTH, 8, width of one input beat.
- NUM_BEATS, 4, beats per output word; must be ≥1.
- CNT_WIDTH, $clog2(NUM_BEATS)+1 (derived localparam), width of the beat counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  DATA_WIDTH  input beat.
- valid_in  input  1  input beat valid.
- ready_in  output  1  block can accept a beat.
- data_out  output  NUM_BEATS*DATA_WIDTH  packed word.
- valid_out  output  1  packed word valid.
- ready_out  input  1  downstream accepts the word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: data_out=0, valid_out=0, ready_in=1, beat counter=0, assembly register=0, state=EMPTY.
- Handshakes: insert = valid_in & ready_in; remove = valid_out & ready_out.
- Packing order: beat k of a word (k = 0..NUM_BEATS-1, arrival order) occupies data_out[k*DATA_WIDTH +: DATA_WIDTH]. The first beat is LSB.
- Storage: assembly register holds beats 0..NUM_BEATS-2 plus the counter. The output register holds data_out/valid_out.
- State machine (state_t) for the assembly side:
  - EMPTY: counter=0. An insert with NUM_BEATS>1 goes to PARTIAL.
  - PARTIAL: an insert that is not the final beat stores the beat and increments the counter.
  - Final-beat insert (counter == NUM_BEATS-1), from EMPTY or PARTIAL:
    - If the output is free (!valid_out | ready_out): write {data_in, assembled beats} to the output register, set valid_out=1, and go to EMPTY with counter=0.
    - Otherwise: store the beat and go to FULL.
  - FULL: all beats are held and the output is occupied. ready_in=0.
    - On remove, transfer the assembly to the output register the same cycle (valid_out stays 1) and go to EMPTY.
- ready_in = (state != FULL). It is a registered next-state decode, with no combinational path from ready_out or valid_in.
- valid_out clears on remove only when no new word is written the same cycle.
- data_out is stable while valid_out=1 and ready_out=0.
- Latency: data_out is valid 1 cycle after the final-beat insert. Throughput is 1 beat/cycle with ready_out held at 1; there is no bubble between words.
- NUM_BEATS=1: every insert is a final beat and the block degenerates to a single register stage with FULL stall.
- Reset mid-word: a partial word is discarded and no output is produced.
- valid_in while ready_in=0 is ignored and the data is not sampled.

Optional Feature:
- Macro: STREAM_PACKER_LAST_EN.
- When defined:
  - Adds ports last_in (input, 1) and last_out (output, 1, reset 0).
  - An insert with last_in=1 is treated as the final beat regardless of the counter. Unfilled upper beats of the word are zero.
  - last_out is registered with data_out and asserts for that word only.
  - last_in on beat NUM_BEATS-1 behaves as a normal full word with last_out=1.
- When undefined: the ports are absent and only counter-based completion applies.

Decomposition:
- Package stream_packer_pkg: state_t enum {EMPTY, PARTIAL, FULL} (2 bits), and a function for beat-slot index arithmetic.
- Sub-module: reuse register_slice for the output register (data_out, valid_out) and the state register. Assembly storage stays inline.

Test Plan:
- DATA_WIDTH=8, NUM_BEATS=4, ready_out=1, beats 0x11,0x22,0x33,0x44 back-to-back → data_out=0x44332211, valid_out=1 exactly one cycle after the 4th insert; ready_in stays 1.
- 8 continuous beats 0x01..0x08 with ready_out=1 → words 0x04030201 then 0x08070605 on consecutive word boundaries, with no ready_in deassertion.
- ready_out=0, send 8 beats → first word held stable. After beat 8, state is FULL and ready_in=0 on the next cycle. Raise ready_out → second word 0x08070605 appears the next cycle and ready_in=1.
- Assert rst after 2 beats (0xAA,0xBB), then send 0x01..0x04 → output 0x04030201 only; 0xAA/0xBB never appear.
- NUM_BEATS=1, toggling ready_out → each beat is passed through with 1-cycle latency; no beat is lost or duplicated, checked against a scoreboard over 200 random beats.
- STREAM_PACKER_LAST_EN: beats 0x11,0x22 with last_in on 0x22 → data_out=0x00002211 with last_out=1. The next word starts at slot 0.
